// File: rtl/sram_fifo_ctrl.sv
// Show-ahead FIFO controller in front of a 1-cycle-latency dual-port SRAM.
// One output holding stage sits after the SRAM, so capacity is DEPTH+1.
module sram_fifo_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        push_valid_i,
  output logic                        push_ready_o,
  input  logic [WIDTH-1:0]            push_data_i,
  output logic                        pop_valid_o,
  input  logic                        pop_ready_i,
  output logic [WIDTH-1:0]            pop_data_o,
  output logic                        mem_wen_o,
  output logic [ADDR_W-1:0]           mem_waddr_o,
  output logic [WIDTH-1:0]            mem_wdata_o,
  output logic                        mem_ren_o,
  output logic [ADDR_W-1:0]           mem_raddr_o,
  input  logic [WIDTH-1:0]            mem_rdata_i,
  output logic [$clog2(DEPTH+2)-1:0]  count_o,
  output logic                        full_o,
  output logic                        empty_o
);
  localparam int CW = $clog2(DEPTH + 2);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]     mem_cnt;
  logic              out_valid;
  logic              act, push_fire, pop_fire, rd_issue;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // flush (and reset) silence every fire and memory enable in the same cycle
  assign act          = !flush_i && !rst_i;
  assign push_ready_o = (mem_cnt != CW'(DEPTH));
  assign push_fire    = push_valid_i && push_ready_o && act;
  assign pop_fire     = out_valid && pop_ready_i && act;
  // refill the output stage whenever it is empty or being drained this cycle
  assign rd_issue     = (mem_cnt != '0) && (!out_valid || pop_fire) && act;

  assign mem_wen_o   = push_fire;
  assign mem_waddr_o = wr_ptr;
  assign mem_wdata_o = push_data_i;
  assign mem_ren_o   = rd_issue;
  assign mem_raddr_o = rd_ptr;

  assign pop_valid_o = out_valid;
  assign pop_data_o  = mem_rdata_i;   // SRAM holds rdata while ren is low
  assign count_o     = mem_cnt + CW'(out_valid);
  assign full_o      = !push_ready_o;
  assign empty_o     = (count_o == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (flush_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_issue)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_fire, rd_issue})
        2'b10:   mem_cnt <= mem_cnt + CW'(1);
        2'b01:   mem_cnt <= mem_cnt - CW'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (rd_issue)      out_valid <= 1'b1;
      else if (pop_fire) out_valid <= 1'b0;
    end
  end
endmodule
